// File: rtl/memory.sv
// memory: single-clock simple dual-port RAM with a registered read port.
//   One write port and one read port with independent addresses. The read
//   data is registered, so it appears one cycle after the request. A read
//   and a write to the same valid address in one cycle return the new data
//   (write-first). Out-of-range addresses are ignored on write and read
//   back as zero. The reset is synchronous and clears the storage and the
//   output register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high, overrides both ports
//   write_flag write enable
//   data_in    write data            [DATA_W]
//   addr_w     write address         [ADDR_SIZE]
//   read_flag  read enable
//   addr_r     read address          [ADDR_SIZE]
//   data_out   registered read data  [DATA_W]
module memory #(
  parameter int MEM_SIZE = 6,
  parameter int DATA_W   = 10,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_flag,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [ADDR_SIZE-1:0] addr_w,
  input  logic                 read_flag,
  input  logic [ADDR_SIZE-1:0] addr_r,
  output logic [DATA_W-1:0]    data_out
);

  logic [MEM_SIZE-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]               data_out_q, data_out_d;
  logic [DATA_W-1:0]               rd_word;
  logic                            rd_hit;

  // Addresses are decoded by comparing against every word index, so an
  // address at or beyond MEM_SIZE simply matches nothing: writes there are
  // dropped and reads there see no hit (zero), without any array index
  // ever going out of range.
  always_comb begin
    mem_d   = mem_q;
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (write_flag && addr_w == ADDR_SIZE'(i)) mem_d[i] = data_in;
      if (addr_r == ADDR_SIZE'(i)) begin
        rd_word = mem_q[i];
        rd_hit  = 1'b1;
      end
    end
  end

  // Write-first bypass only applies when the shared address is valid;
  // an out-of-range collision still reads zero.
  always_comb begin
    data_out_d = data_out_q;
    if (read_flag) begin
      if (!rd_hit)                              data_out_d = '0;
      else if (write_flag && addr_w == addr_r)  data_out_d = data_in;
      else                                      data_out_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
module tb_memory;
  localparam int MEM_SIZE = 6;
  localparam int DATA_W   = 10;
  localparam int AW       = $clog2(MEM_SIZE);

  logic              clk = 1'b0;
  logic              rst;
  logic              write_flag;
  logic [DATA_W-1:0] data_in;
  logic [AW-1:0]     addr_w;
  logic              read_flag;
  logic [AW-1:0]     addr_r;
  logic [DATA_W-1:0] data_out;

  int n_chk  = 0;
  int n_fail = 0;

  memory #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_flag (write_flag),
    .data_in    (data_in),
    .addr_w     (addr_w),
    .read_flag  (read_flag),
    .addr_r     (addr_r),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, take the rising edge, settle past it.
  task automatic step(input logic r, input logic wf, input logic [DATA_W-1:0] din,
                      input logic [AW-1:0] aw, input logic rf, input logic [AW-1:0] ar);
    rst = r; write_flag = wf; data_in = din; addr_w = aw;
    read_flag = rf; addr_r = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b0, 1'b1, d, a, 1'b0, '0);
  endtask

  logic [DATA_W-1:0] exp_mem [MEM_SIZE];

  initial begin
    rst = 1'b0; write_flag = 1'b0; data_in = '0; addr_w = '0;
    read_flag = 1'b0; addr_r = '0;
    @(negedge clk);

    // Fill memory with a non-zero pattern so reset has something to clear.
    for (int i = 0; i < MEM_SIZE; i++) wr(AW'(i), 10'h2AA);
    rd(3'd2);
    chk("prefill_rd2", data_out, 10'h2AA);

    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    chk("reset_dout", data_out, 10'h000);
    for (int i = 0; i < MEM_SIZE; i++) begin
      rd(AW'(i));
      chk($sformatf("reset_rd%0d", i), data_out, 10'h000);
    end

    // Write then read.
    wr(3'd0, 10'h123);
    chk("wr_no_rd_hold", data_out, 10'h000);
    rd(3'd0);
    chk("wr_rd0", data_out, 10'h123);

    // Same-address collision: write-first.
    step(1'b0, 1'b1, 10'h0BC, 3'd1, 1'b1, 3'd1);
    chk("coll_bypass", data_out, 10'h0BC);
    rd(3'd1);
    chk("coll_reread", data_out, 10'h0BC);

    // Hold with read_flag low, even with writes going on.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 2), 10'h321, 3'd5, 1'b0, 3'd1);
      chk($sformatf("hold%0d", i), data_out, 10'h0BC);
    end
    wr(3'd5, 10'h000);

    // Independent ports.
    step(1'b0, 1'b1, 10'h0DF, 3'd2, 1'b1, 3'd3);
    chk("indep_rd3", data_out, 10'h000);
    rd(3'd2);
    chk("indep_rd2", data_out, 10'h0DF);
    step(1'b0, 1'b1, 10'h055, 3'd3, 1'b1, 3'd2);
    chk("indep_old", data_out, 10'h0DF);
    rd(3'd3);
    chk("indep_new3", data_out, 10'h055);

    // Out-of-range writes are dropped.
    wr(3'd6, 10'h3FF);
    wr(3'd7, 10'h3FF);
    exp_mem[0] = 10'h123; exp_mem[1] = 10'h0BC; exp_mem[2] = 10'h0DF;
    exp_mem[3] = 10'h055; exp_mem[4] = 10'h000; exp_mem[5] = 10'h000;
    for (int i = 0; i < MEM_SIZE; i++) begin
      rd(AW'(i));
      chk($sformatf("oob_wr_rd%0d", i), data_out, exp_mem[i]);
    end

    // Out-of-range reads return zero (from a non-zero output).
    rd(3'd0);
    chk("pre_oob_rd", data_out, 10'h123);
    rd(3'd7);
    chk("oob_rd7", data_out, 10'h000);
    rd(3'd1);
    step(1'b0, 1'b1, 10'h3FF, 3'd6, 1'b1, 3'd6);
    chk("oob_coll6", data_out, 10'h000);

    // Reset priority over a simultaneous write and read.
    rd(3'd0);
    step(1'b1, 1'b1, 10'h155, 3'd4, 1'b1, 3'd0);
    chk("rst_prio_dout", data_out, 10'h000);
    rd(3'd4);
    chk("rst_prio_rd4", data_out, 10'h000);
    rd(3'd0);
    chk("rst_prio_rd0", data_out, 10'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
